// File: rtl/gl_cmd_fetch.sv
// gl_cmd_fetch: walks the GL command stream in instruction BRAM, sizes and rewrites each
// command, and queues {header, payload addr, len} toward decode. GL_FETCH_BOUND_EN enables the TEXT_END check.
module gl_cmd_fetch #(
    parameter int                WIDTH      = 32,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] TEXT_START = '0,
    parameter logic [ADDR_W-1:0] TEXT_END   = '1,
    parameter int                BRAM_LAT   = 1,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_en,
    output logic [ADDR_W-1:0] o_inst_addr,
    input  logic [WIDTH-1:0]  i_inst_in,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [WIDTH-1:0]  o_out_inst,
    output logic [ADDR_W-1:0] o_out_payload_addr,
    output logic [4:0]        o_out_len,
    output logic              o_halted,
    output logic              o_err
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WCNT_W = (BRAM_LAT > 1) ? $clog2(BRAM_LAT) : 1;
    localparam logic [WIDTH-1:0] MULTMATRIX_HDR = WIDTH'(32'h80001011);

    typedef struct packed {
        logic [WIDTH-1:0]  inst;
        logic [ADDR_W-1:0] paddr;
        logic [4:0]        len;
    } entry_t;

    typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_DECODE, S_HALT} state_t;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [WCNT_W-1:0]   r_wcnt;
    logic                r_halted;

    entry_t              r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr, r_rd;
    logic [CNT_W-1:0]    r_count;

    logic [7:0]          w_opcode;
    logic [4:0]          w_len;
    logic                w_rewrite;
    logic                w_is_end;
    logic                w_oob;
    logic                w_load_wcnt;
    logic                w_push;
    logic                w_pop;
    logic                w_halt_set;
    entry_t              w_entry;
    entry_t              w_head;

    // Command sizing and macro-op rewrite table
    assign w_opcode = i_inst_in[7:0];
    assign w_is_end = (w_opcode == 8'hFF);

    always_comb begin
        w_len     = 5'd1;
        w_rewrite = 1'b0;
        case (w_opcode)
            8'h03, 8'h04: w_len = 5'd4;
            8'h11, 8'h13: w_len = 5'd17;
            8'h16, 8'h17, 8'h18, 8'h1A, 8'h1B: begin
                w_len     = 5'd17;
                w_rewrite = 1'b1;
            end
            8'h19:   w_len = 5'd5;
            default: w_len = 5'd1;
        endcase
    end

`ifdef GL_FETCH_BOUND_EN
    logic [ADDR_W:0] w_end_sum;
    logic            r_err;
    // One extra bit so a command straddling the top of the address space is still caught
    assign w_end_sum = {1'b0, r_pc} + (ADDR_W+1)'(w_len);
    assign w_oob     = (w_end_sum > {1'b0, TEXT_END});
`else
    assign w_oob = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge i_clk) begin
        if (!i_reset) r_state <= S_ISSUE;
        else          r_state <= w_next;
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_ISSUE:
                if (i_en && !r_halted && (r_count < CNT_W'(FIFO_DEPTH))) w_next = S_WAIT;
            S_WAIT:
                if (r_wcnt == '0) w_next = S_DECODE;
            S_DECODE:
                w_next = (w_is_end || w_oob) ? S_HALT : S_ISSUE;
            S_HALT:
                w_next = S_HALT;
            default:
                w_next = S_ISSUE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_load_wcnt = 1'b0;
        w_push      = 1'b0;
        w_halt_set  = 1'b0;
        case (r_state)
            S_ISSUE:  w_load_wcnt = (w_next == S_WAIT);
            S_DECODE: begin
                w_push     = !w_is_end && !w_oob;
                w_halt_set = w_is_end || w_oob;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_pc     <= TEXT_START;
            r_wcnt   <= '0;
            r_halted <= 1'b0;
        end else begin
            if (w_load_wcnt)
                r_wcnt <= WCNT_W'(BRAM_LAT - 1);
            else if (r_state == S_WAIT && r_wcnt != '0)
                r_wcnt <= r_wcnt - 1'b1;
            if (w_push)
                r_pc <= r_pc + ADDR_W'(w_len);
            if (w_halt_set)
                r_halted <= 1'b1;
        end
    end

`ifdef GL_FETCH_BOUND_EN
    always_ff @(posedge i_clk) begin
        if (!i_reset)                               r_err <= 1'b0;
        else if (r_state == S_DECODE && !w_is_end && w_oob) r_err <= 1'b1;
    end
    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    assign o_inst_addr = r_pc;
    assign o_halted    = r_halted;

    assign w_entry.inst  = w_rewrite ? MULTMATRIX_HDR : i_inst_in;
    assign w_entry.paddr = r_pc + ADDR_W'(1);
    assign w_entry.len   = w_len;

    // Output queue; ISSUE only starts a read when a slot is free, so a push never overflows
    assign w_pop = o_out_valid && i_out_ready;

    always_ff @(posedge i_clk) begin
        if (w_push) r_fifo[r_wr] <= w_entry;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head             = r_fifo[r_rd];
    assign o_out_valid        = (r_count != '0);
    assign o_out_inst         = o_out_valid ? w_head.inst  : '0;
    assign o_out_payload_addr = o_out_valid ? w_head.paddr : '0;
    assign o_out_len          = o_out_valid ? w_head.len   : '0;

endmodule

// File: tb/tb_gl_cmd_fetch.sv
// Scoreboard bench for gl_cmd_fetch: a command-stream model fills the expected queue,
// a monitor compares every accepted entry; per-scenario tasks check addresses and flags.
module tb_gl_cmd_fetch;

    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] inst_addr;
    logic [31:0] inst_in;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_paddr;
    logic [4:0]  out_len;
    logic        halted;
    logic        err;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] paddr;
        logic [4:0]  len;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem [256];
    logic [31:0] rd_pipe [LAT];
    logic [31:0] exp_addr;
    logic        exp_err;
    int          checks = 0;
    int          failures = 0;

    gl_cmd_fetch #(
        .WIDTH(32), .ADDR_W(32), .TEXT_START(32'd0), .TEXT_END(32'd16),
        .BRAM_LAT(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_en(en),
        .o_inst_addr(inst_addr), .i_inst_in(inst_in),
        .o_out_valid(out_valid), .i_out_ready(ready),
        .o_out_inst(out_inst), .o_out_payload_addr(out_paddr), .o_out_len(out_len),
        .o_halted(halted), .o_err(err)
    );

    always #5 clk = ~clk;

    // BRAM with LAT cycles of read latency
    always @(posedge clk) begin
        rd_pipe[0] <= mem[inst_addr[7:0]];
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign inst_in = rd_pipe[LAT-1];

    // Every accepted head entry must match the oldest expected entry
    always @(negedge clk) begin
        if (out_valid && ready) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_entry got inst=%h paddr=%0d len=%0d, required none",
                         out_inst, out_paddr, out_len);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (out_inst !== e.inst || out_paddr !== e.paddr || out_len !== e.len) begin
                    failures++;
                    $display("FAIL entry got {%h,%0d,%0d} required {%h,%0d,%0d}",
                             out_inst, out_paddr, out_len, e.inst, e.paddr, e.len);
                end
            end
        end
    end

    // Walks mem from address 0 the way the fetcher should, queueing expected entries
    task automatic build_model();
        logic [31:0] pc;
        logic [31:0] hdr;
        logic [4:0]  len;
        logic        rw;
        exp_t        e;
        pc = 32'd0;
        exp_err = 1'b0;
        exp_addr = 32'd0;
        for (int n = 0; n < 64; n++) begin
            hdr = mem[pc[7:0]];
            if (hdr[7:0] == 8'hFF) begin
                exp_addr = pc;
                return;
            end
            rw = 1'b0;
            case (hdr[7:0])
                8'h03, 8'h04: len = 5'd4;
                8'h11, 8'h13: len = 5'd17;
                8'h16, 8'h17, 8'h18, 8'h1A, 8'h1B: begin len = 5'd17; rw = 1'b1; end
                8'h19:   len = 5'd5;
                default: len = 5'd1;
            endcase
`ifdef GL_FETCH_BOUND_EN
            if (({1'b0, pc} + {28'd0, len}) > 33'd16) begin
                exp_err = 1'b1;
                exp_addr = pc;
                return;
            end
`endif
            e.inst = rw ? 32'h80001011 : hdr;
            e.paddr = pc + 32'd1;
            e.len = len;
            q.push_back(e);
            pc = pc + {27'd0, len};
        end
    endtask

    task automatic begin_test();
        @(posedge clk); #1;
        reset = 1'b0;
        en = 1'b0;
        ready = 1'b0;
        q.delete();
        foreach (mem[i]) mem[i] = 32'd0;
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (halted && !out_valid && q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        begin_test();
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b required 0", out_valid); end
        checks++; if (inst_addr !== 32'd0) begin failures++; $display("FAIL reset_addr got %0d required 0", inst_addr); end
        checks++; if (halted !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_flags got halted=%b err=%b required 0/0", halted, err); end
        checks++; if (out_inst !== 32'd0 || out_paddr !== 32'd0 || out_len !== 5'd0) begin
            failures++; $display("FAIL reset_head got {%h,%0d,%0d} required zeros", out_inst, out_paddr, out_len);
        end
    endtask

    task automatic test_stream();
        bit ok;
        begin_test();
        mem[0] = 32'h12340003;
        mem[4] = 32'h00AB0004;
        mem[8] = 32'h0000002A;
        mem[9] = 32'h000000FF;
        build_model();
        en = 1'b1;
        ready = 1'b1;
        release_reset();
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL stream_done timeout, %0d entries outstanding", q.size()); end
        checks++; if (inst_addr !== 32'd9) begin failures++; $display("FAIL stream_end_addr got %0d required 9", inst_addr); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL stream_err got %b required 0", err); end
    endtask

    task automatic test_rewrite();
        bit ok;
        begin_test();
        mem[0]   = 32'h55AA0016;
        mem[17]  = 32'h00000017;
        mem[34]  = 32'h00000018;
        mem[51]  = 32'h0000001A;
        mem[68]  = 32'h0000001B;
        mem[85]  = 32'h77000011;
        mem[102] = 32'h66000019;
        mem[107] = 32'h000000FF;
        build_model();
        en = 1'b1;
        ready = 1'b1;
        release_reset();
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL rewrite_done timeout, %0d entries outstanding", q.size()); end
        checks++; if (inst_addr !== exp_addr) begin failures++; $display("FAIL rewrite_end_addr got %0d required %0d", inst_addr, exp_addr); end
        checks++; if (err !== exp_err) begin failures++; $display("FAIL rewrite_err got %b required %b", err, exp_err); end
    endtask

    task automatic test_en_gate();
        bit ok;
        begin_test();
        mem[0] = 32'h00000021;
        mem[1] = 32'h00000022;
        mem[2] = 32'h000000FF;
        build_model();
        en = 1'b1;
        release_reset();
        @(posedge clk); #1;
        en = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++; if (inst_addr !== 32'd1 || !out_valid) begin
            failures++; $display("FAIL en_inflight got addr=%0d valid=%b required addr=1 valid=1", inst_addr, out_valid);
        end
        en = 1'b1;
        ready = 1'b1;
        wait_done(ok);
        checks++; if (!ok || inst_addr !== 32'd2) begin
            failures++; $display("FAIL en_resume got done=%b addr=%0d required done=1 addr=2", ok, inst_addr);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        begin_test();
        for (int i = 0; i < 6; i++) mem[i] = 32'hABCD0020 + i;
        mem[6] = 32'h000000FF;
        build_model();
        en = 1'b1;
        release_reset();
        repeat (60) @(posedge clk);
        @(negedge clk);
        checks++; if (inst_addr !== 32'd4) begin failures++; $display("FAIL bp_stall_addr got %0d required 4", inst_addr); end
        checks++; if (!out_valid || out_inst !== q[0].inst || out_paddr !== q[0].paddr) begin
            failures++; $display("FAIL bp_head got valid=%b inst=%h paddr=%0d required valid=1 inst=%h paddr=%0d",
                                 out_valid, out_inst, out_paddr, q[0].inst, q[0].paddr);
        end
        ready = 1'b1;
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_done timeout, %0d entries outstanding", q.size()); end
        checks++; if (inst_addr !== 32'd6) begin failures++; $display("FAIL bp_end_addr got %0d required 6", inst_addr); end
    endtask

    task automatic test_reset_abort();
        bit ok;
        begin_test();
        mem[0] = 32'h00000020;
        mem[1] = 32'h00000003;
        mem[5] = 32'h000000FF;
        build_model();
        en = 1'b1;
        release_reset();
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (inst_addr == 32'd1) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin failures++; $display("FAIL abort_first_cmd timeout, addr=%0d required 1", inst_addr); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || inst_addr !== 32'd0) begin
            failures++; $display("FAIL abort_reset got valid=%b addr=%0d required valid=0 addr=0", out_valid, inst_addr);
        end
        q.delete();
        mem[0] = 32'h000000FF;
        build_model();
        ready = 1'b1;
        release_reset();
        wait_done(ok);
        checks++; if (!ok || inst_addr !== 32'd0) begin
            failures++; $display("FAIL abort_after got done=%b addr=%0d required done=1 addr=0", ok, inst_addr);
        end
    endtask

    task automatic test_full_push_pop();
        bit ok;
        begin_test();
        for (int i = 0; i < 8; i++) mem[i] = 32'hC0DE0030 + i;
        mem[8] = 32'h000000FF;
        build_model();
        en = 1'b1;
        release_reset();
        repeat (40) @(posedge clk);
        @(negedge clk);
        checks++; if (inst_addr !== 32'd4) begin failures++; $display("FAIL full_stall_addr got %0d required 4", inst_addr); end
        // One pop frees a slot; the refill's DECODE then lands LAT+2 cycles later
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        #1;
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        checks++; if (inst_addr !== 32'd6) begin failures++; $display("FAIL full_pushpop_addr got %0d required 6", inst_addr); end
        checks++; if (out_inst !== q[0].inst) begin failures++; $display("FAIL full_head got %h required %h", out_inst, q[0].inst); end
        ready = 1'b1;
        wait_done(ok);
        checks++; if (!ok || inst_addr !== 32'd8) begin
            failures++; $display("FAIL full_done got done=%b addr=%0d required done=1 addr=8", ok, inst_addr);
        end
    endtask

    task automatic test_bound();
        bit ok;
        begin_test();
        mem[0]  = 32'h00000013;
        mem[17] = 32'h000000FF;
        build_model();
        en = 1'b1;
        ready = 1'b1;
        release_reset();
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL bound_done timeout, %0d entries outstanding", q.size()); end
        checks++; if (err !== exp_err) begin failures++; $display("FAIL bound_err got %b required %b", err, exp_err); end
        checks++; if (inst_addr !== exp_addr) begin failures++; $display("FAIL bound_addr got %0d required %0d", inst_addr, exp_addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_rewrite();
        test_en_gate();
        test_backpressure();
        test_reset_abort();
        test_full_push_pop();
        test_bound();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
